// File: rtl/usb_rx_bit_decoder.sv
// USB full-speed receive bit decoder: bit-clock recovery, NRZI decode, bit unstuffing, SE0 detect.
// Optional stuffing-violation reporting is enabled by defining USB_RX_STUFF_ERR_EN.
module usb_rx_bit_decoder #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned SAMPLE_POINT = 3
) (
  input  logic clk,
  input  logic n_rst,
  input  logic d_plus,
  input  logic d_minus,
  input  logic rcv_active,
  output logic d_orig,
  output logic shift_enable,
  output logic eop,
  output logic stuff_err
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax    = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntSample = CntW'(SAMPLE_POINT);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);

  logic            d_plus_prev;
  logic [CntW-1:0] bit_cnt;
  logic [2:0]      ones_cnt;
  logic            last_bit;

  logic line_edge;
  logic se0;
  logic strobe;
  logic dec_bit;
  logic stuffed;

  assign se0       = ~d_plus & ~d_minus;
  // Transitions into SE0 must not resynchronise the bit clock.
  assign line_edge = (d_plus != d_plus_prev) & ~se0;
  assign strobe    = rcv_active & (bit_cnt == CntSample);
  assign dec_bit   = (d_plus == last_bit);
  assign stuffed   = (ones_cnt == 3'd6);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      d_plus_prev  <= 1'b1;
      bit_cnt      <= '0;
      ones_cnt     <= 3'd0;
      last_bit     <= 1'b1;
      d_orig       <= 1'b1;
      shift_enable <= 1'b0;
      eop          <= 1'b0;
    end else begin
      d_plus_prev  <= d_plus;
      shift_enable <= 1'b0;
      eop          <= 1'b0;
      if (!rcv_active) begin
        bit_cnt  <= '0;
        ones_cnt <= 3'd0;
        last_bit <= 1'b1;
      end else begin
        if (line_edge) begin
          bit_cnt <= CntOne;
        end else if (bit_cnt == CntMax) begin
          bit_cnt <= '0;
        end else begin
          bit_cnt <= bit_cnt + CntOne;
        end

        if (strobe) begin
          if (se0) begin
            eop      <= 1'b1;
            ones_cnt <= 3'd0;
            last_bit <= 1'b1;
          end else begin
            last_bit <= d_plus;
            if (stuffed) begin
              ones_cnt <= 3'd0;
            end else begin
              d_orig       <= dec_bit;
              shift_enable <= 1'b1;
              ones_cnt     <= dec_bit ? (ones_cnt + 3'd1) : 3'd0;
            end
          end
        end
      end
    end
  end

`ifdef USB_RX_STUFF_ERR_EN
  logic stuff_err_q;

  // A stuffed bit that decodes as 1 means seven consecutive ones on the wire.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stuff_err_q <= 1'b0;
    end else begin
      stuff_err_q <= strobe & ~se0 & stuffed & dec_bit;
    end
  end

  assign stuff_err = stuff_err_q;
`else
  assign stuff_err = 1'b0;
`endif

endmodule
